// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path definitions for the CPU sequencer and the bus
// output-signal decoder.
// Contents:
//   state_t        - 5-bit execution state codes driven to the decoder
//   OPC_*          - opcode values carried in the instruction opcode field
//   *_MSB / *_LSB  - bit positions of the OPC, RX and RY instruction fields
//   is_final_state - true for states in which an instruction completes
//   opcode_of      - extracts the opcode field from an instruction word
package cpu_ctrl_pkg;

  localparam int INSTR_W = 23;
  localparam int STATE_W = 5;
  localparam int OPC_W   = 3;

  // Instruction field positions. RX and RY are only meaningful to the
  // decoder; the sequencer passes them through untouched.
  localparam int OPC_MSB = 22;
  localparam int OPC_LSB = 20;
  localparam int RX_MSB  = 19;
  localparam int RX_LSB  = 16;
  localparam int RY_MSB  = 15;
  localparam int RY_LSB  = 12;

  // Legal opcodes; any opcode with the top bit set is illegal.
  localparam logic [OPC_W-1:0] OPC_LOAD = 3'b000;
  localparam logic [OPC_W-1:0] OPC_MOV  = 3'b001;
  localparam logic [OPC_W-1:0] OPC_ADD  = 3'b010;
  localparam logic [OPC_W-1:0] OPC_SUB  = 3'b011;

  // Execution state codes. These encodings are consumed directly by the
  // decoder, so they must never change independently of it.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 5'b00000,
    ST_LOAD   = 5'b00001,
    ST_MOV    = 5'b00010,
    ST_ARITH1 = 5'b00011,
    ST_ARITH2 = 5'b00100,
    ST_ARITH3 = 5'b00101
  } state_t;

  // An instruction retires in its final state; a new one may be taken there.
  function automatic logic is_final_state(input state_t s);
    return (s == ST_LOAD) || (s == ST_MOV) || (s == ST_ARITH3);
  endfunction

  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instr_sequencer_opcode_classify.sv
// Combinational opcode classifier.
// Ports:
//   opcode      in  3  opcode field of an instruction
//   first_state out 5  first execution state for a legal opcode (IDLE if illegal)
//   is_arith    out 1  opcode is ADD or SUB
//   is_sub      out 1  opcode is SUB
//   is_illegal  out 1  opcode is not a recognised instruction
module opcode_classify
  import cpu_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output state_t           first_state,
  output logic             is_arith,
  output logic             is_sub,
  output logic             is_illegal
);

  // Decode the opcode into its entry state and class flags. Anything not
  // listed (the whole 1xx range) is flagged illegal and maps to IDLE.
  always_comb begin
    first_state = ST_IDLE;
    is_arith    = 1'b0;
    is_sub      = 1'b0;
    is_illegal  = 1'b0;
    case (opcode)
      OPC_LOAD: first_state = ST_LOAD;
      OPC_MOV:  first_state = ST_MOV;
      OPC_ADD: begin
        first_state = ST_ARITH1;
        is_arith    = 1'b1;
      end
      OPC_SUB: begin
        first_state = ST_ARITH1;
        is_arith    = 1'b1;
        is_sub      = 1'b1;
      end
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Control sequencer feeding the bus output-signal decoder.
// Takes instructions from fetch over a valid/ready handshake, latches them,
// and walks the execution state code the decoder consumes.
// Ports:
//   clk         in  1      rising-edge clock
//   rst_n       in  1      synchronous active-low reset
//   instr_in    in  23     instruction offered by fetch
//   instr_valid in  1      instr_in is valid
//   instr_ready out 1      an instruction can be accepted this cycle
//   hold        in  1      bus stall, freezes execution
//   state       out 5      execution state code to the decoder
//   instr       out 23     latched instruction register to the decoder
//   alu_sub     out 1      1 = subtract, 0 = add (meaningful in ARITH states)
//   done        out 1      final execution cycle of an instruction
//   illegal     out 1      pulse in the cycle after an illegal opcode is taken
//   retired     out CNT_W  wrapping count of completed instructions
module instr_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               hold,
  output logic [STATE_W-1:0] state,
  output logic [INSTR_W-1:0] instr,
  output logic               alu_sub,
  output logic               done,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired
);

  state_t             state_q;
  state_t             state_d;
  logic [INSTR_W-1:0] instr_q;
  logic               alu_sub_q;
  logic               illegal_q;
  logic [CNT_W-1:0]   retired_q;

  logic               accept;
  state_t             first_state;
  logic               is_arith;
  logic               is_sub;
  logic               is_illegal;

  // Classification is done on the incoming word so the entry state is known
  // in the same cycle the instruction is accepted.
  opcode_classify u_classify (
    .opcode      (opcode_of(instr_in)),
    .first_state (first_state),
    .is_arith    (is_arith),
    .is_sub      (is_sub),
    .is_illegal  (is_illegal)
  );

  // Next-state and handshake outputs. Ready and done depend only on the
  // state register and hold, never on instr_valid, so fetch sees no
  // combinational loop. A final state that sees a new accept moves straight
  // to the next instruction's entry state, giving back-to-back issue.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    done        = 1'b0;

    if (!hold) begin
      instr_ready = (state_q == ST_IDLE) || is_final_state(state_q);
      done        = is_final_state(state_q);
      case (state_q)
        ST_ARITH1: state_d = ST_ARITH2;
        ST_ARITH2: state_d = ST_ARITH3;
        default:   state_d = (accept && !is_illegal) ? first_state : ST_IDLE;
      endcase
    end
  end

  assign accept = instr_valid & instr_ready;

  // State, instruction register, ALU direction, illegal pulse and retire
  // counter. The subtract flag is captured alongside the instruction so it
  // stays constant for the whole execution; an illegal opcode captures 0.
  // Hold needs no explicit term here: it blocks accept and done, and the
  // next-state logic already keeps the state unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      alu_sub_q <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= accept & is_illegal;
      if (accept) begin
        instr_q   <= instr_in;
        alu_sub_q <= is_arith & is_sub;
      end
      if (done) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign state   = state_q;
  assign instr   = instr_q;
  assign alu_sub = alu_sub_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: directed instruction sequences with a
// reference model whose per-cycle expectations are queued when inputs are
// driven and compared when the cycle's outputs are sampled.
module tb_instr_sequencer;

  localparam logic [22:0] I_LOAD = 23'h0_3_0000;
  localparam logic [22:0] I_SUB  = 23'h3_2_1000;
  localparam logic [22:0] I_MOV  = 23'h1_1_2000;
  localparam logic [22:0] I_ADD  = 23'h2_3_4000;
  localparam logic [22:0] I_ILL  = 23'h5_0_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [22:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic        hold;
  logic [4:0]  state;
  logic [22:0] instr;
  logic        alu_sub;
  logic        done;
  logic        illegal;
  logic [15:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [4:0]  state;
    logic [22:0] instr;
    logic        alu_sub;
    logic        done;
    logic        illegal;
    logic [15:0] retired;
    logic        ready;
  } exp_t;

  exp_t sb_q[$];

  logic [4:0]  m_state;
  logic [22:0] m_instr;
  logic [15:0] m_retired;
  logic        m_illegal;

  instr_sequencer #(.CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .hold        (hold),
    .state       (state),
    .instr       (instr),
    .alu_sub     (alu_sub),
    .done        (done),
    .illegal     (illegal),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state   = 5'd0;
    m_instr   = '0;
    m_retired = '0;
    m_illegal = 1'b0;
  endtask

  // Drive one cycle of inputs, queue what this cycle should show, then
  // advance the model across the coming clock edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [22:0] w, input logic h);
    exp_t e;
    logic fin, rdy, acc;
    @(posedge clk);
    #1;
    rst_n       = r;
    instr_valid = v;
    instr_in    = w;
    hold        = h;

    fin = (m_state == 5'd1) || (m_state == 5'd2) || (m_state == 5'd5);
    rdy = !h && ((m_state == 5'd0) || fin);
    acc = v && rdy;

    e.state   = m_state;
    e.instr   = m_instr;
    e.alu_sub = (m_instr[22:20] == 3'b011);
    e.done    = fin && !h;
    e.illegal = m_illegal;
    e.retired = m_retired;
    e.ready   = rdy;
    sb_q.push_back(e);

    if (!r) begin
      model_reset();
    end else if (h) begin
      m_illegal = 1'b0;
    end else begin
      m_illegal = acc && w[22];
      if (e.done) m_retired = m_retired + 16'd1;
      if (m_state == 5'd3)      m_state = 5'd4;
      else if (m_state == 5'd4) m_state = 5'd5;
      else if (acc && !w[22])   m_state = w[21] ? 5'd3 : (w[20] ? 5'd2 : 5'd1);
      else                      m_state = 5'd0;
      if (acc) m_instr = w;
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    @(negedge clk);
    n_checks++;
    assert (sb_q.size() != 0)
    else begin
      n_errors++;
      $error("[TB] FAIL scoreboard: observed empty queue expected 1 entry");
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_val("state",       32'(state),       32'(e.state));
      check_val("instr",       32'(instr),       32'(e.instr));
      check_val("alu_sub",     32'(alu_sub),     32'(e.alu_sub));
      check_val("done",        32'(done),        32'(e.done));
      check_val("illegal",     32'(illegal),     32'(e.illegal));
      check_val("retired",     32'(retired),     32'(e.retired));
      check_val("instr_ready", 32'(instr_ready), 32'(e.ready));
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [22:0] w, input logic h);
    applyStimulus(r, v, w, h);
    checkOutput();
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr_in    = '0;
    hold        = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset state
    cyc(1, 0, '0, 0);
    check_val("rst_state",   32'(state),       32'h0);
    check_val("rst_ready",   32'(instr_ready), 32'h1);
    check_val("rst_retired", 32'(retired),     32'h0);

    // Single LOAD
    cyc(1, 1, I_LOAD, 0);
    cyc(1, 0, '0, 0);
    check_val("load_state", 32'(state), 32'h1);
    check_val("load_done",  32'(done),  32'h1);
    cyc(1, 0, '0, 0);
    check_val("load_idle",    32'(state),   32'h0);
    check_val("load_retired", 32'(retired), 32'h1);

    // SUB walks the three ARITH states
    cyc(1, 1, I_SUB, 0);
    cyc(1, 0, '0, 0);
    check_val("sub_a1",      32'(state),   32'h3);
    check_val("sub_a1_alu",  32'(alu_sub), 32'h1);
    check_val("sub_a1_done", 32'(done),    32'h0);
    cyc(1, 0, '0, 0);
    check_val("sub_a2",      32'(state),   32'h4);
    check_val("sub_a2_done", 32'(done),    32'h0);
    cyc(1, 0, '0, 0);
    check_val("sub_a3",      32'(state),   32'h5);
    check_val("sub_a3_alu",  32'(alu_sub), 32'h1);
    check_val("sub_a3_done", 32'(done),    32'h1);
    cyc(1, 0, '0, 0);
    check_val("sub_retired", 32'(retired), 32'h2);

    // MOV, MOV, ADD back-to-back with no IDLE bubble
    cyc(1, 1, I_MOV, 0);
    cyc(1, 1, I_MOV, 0);
    check_val("b2b_mov1",  32'(state),       32'h2);
    check_val("b2b_ready", 32'(instr_ready), 32'h1);
    cyc(1, 1, I_ADD, 0);
    check_val("b2b_mov2", 32'(state), 32'h2);
    cyc(1, 0, '0, 0);
    check_val("b2b_add_a1",  32'(state),   32'h3);
    check_val("b2b_add_alu", 32'(alu_sub), 32'h0);
    cyc(1, 0, '0, 0);
    cyc(1, 0, '0, 0);
    check_val("b2b_add_a3", 32'(state), 32'h5);
    cyc(1, 0, '0, 0);
    check_val("b2b_retired", 32'(retired), 32'h5);

    // Hold for four cycles in ARITH2 while fetch offers a LOAD
    cyc(1, 1, I_ADD, 0);
    cyc(1, 0, '0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, I_LOAD, 1);
      check_val("hold_state", 32'(state),       32'h4);
      check_val("hold_ready", 32'(instr_ready), 32'h0);
      check_val("hold_done",  32'(done),        32'h0);
      check_val("hold_instr", 32'(instr),       32'(I_ADD));
    end
    cyc(1, 0, '0, 0);
    check_val("hold_release", 32'(state), 32'h4);
    cyc(1, 0, '0, 0);
    check_val("hold_a3",      32'(state), 32'h5);
    check_val("hold_a3_done", 32'(done),  32'h1);
    cyc(1, 0, '0, 0);
    check_val("hold_retired", 32'(retired), 32'h6);

    // Illegal opcode 101
    cyc(1, 1, I_ILL, 0);
    cyc(1, 0, '0, 0);
    check_val("ill_pulse",   32'(illegal), 32'h1);
    check_val("ill_state",   32'(state),   32'h0);
    check_val("ill_retired", 32'(retired), 32'h6);
    cyc(1, 0, '0, 0);
    check_val("ill_clear", 32'(illegal), 32'h0);

    // Reset asserted during ARITH2
    cyc(1, 1, I_SUB, 0);
    cyc(1, 0, '0, 0);
    cyc(0, 0, '0, 0);
    check_val("mid_rst_a2", 32'(state), 32'h4);
    cyc(1, 0, '0, 0);
    check_val("mid_rst_state",   32'(state),   32'h0);
    check_val("mid_rst_instr",   32'(instr),   32'h0);
    check_val("mid_rst_retired", 32'(retired), 32'h0);
    check_val("mid_rst_alu",     32'(alu_sub), 32'h0);
    check_val("mid_rst_done",    32'(done),    32'h0);

    // Run the counter to 16'hFFFF, then one more LOAD wraps it to zero
    for (int i = 0; i < 65535; i++) begin
      cyc(1, 1, I_LOAD, 0);
    end
    cyc(1, 0, '0, 0);
    cyc(1, 1, I_LOAD, 0);
    check_val("wrap_full", 32'(retired), 32'hFFFF);
    cyc(1, 0, '0, 0);
    check_val("wrap_done", 32'(done), 32'h1);
    cyc(1, 0, '0, 0);
    check_val("wrap_zero", 32'(retired), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

- Control sequencer immediately upstream of the bus output-signal decoder.
- Accepts 23-bit instructions over a valid/ready handshake and latches them in an instruction register.
- Steps through the 5-bit execution state code the decoder consumes, and drives that decoder's `state` and `instr` inputs directly.
- Reports completion, illegal opcodes and a retired-instruction count to the rest of the CPU.

## Interface
- `CNT_W`, 16, width of retired-instruction counter
- `clk` input 1 — sole clock, rising edge
- `rst_n` input 1 — synchronous, active-low reset
- `instr_in` input 23 — instruction word offered by fetch
- `instr_valid` input 1 — `instr_in` valid
- `instr_ready` output 1 — sequencer can accept an instruction this cycle
- `hold` input 1 — freeze execution (bus stall)
- `state` output 5 — execution state code to the decoder
- `instr` output 23 — latched instruction register to the decoder
- `alu_sub` output 1 — 1 = subtract, 0 = add; valid in ARITH states
- `done` output 1 — one-cycle pulse in the final execution cycle of an instruction
- `illegal` output 1 — one-cycle pulse after an illegal opcode is captured
- `retired` output CNT_W — count of completed instructions

## Operation
- Opcode field is `instr[22:20]`:
  - 000 LOAD, 001 MOV, 010 ADD, 011 SUB.
  - 1xx is illegal.
  - `instr[19:16]` = Rx and `instr[15:12]` = Ry; the sequencer does not interpret these fields.
- States (5-bit codes): IDLE 00000, LOAD 00001, MOV 00010, ARITH1 00011, ARITH2 00100, ARITH3 00101. No other codes are ever driven.
- Transitions:
  - IDLE → LOAD, MOV or ARITH1 on an accepted legal instruction.
  - An accepted illegal instruction keeps the state at IDLE and pulses `illegal` next cycle.
  - LOAD and MOV are final states.
  - ARITH1 → ARITH2 → ARITH3; ARITH3 is final.
  - From a final state: accept the next instruction if it is offered, otherwise go to IDLE.
- Accept = `instr_valid & instr_ready`.
  - `instr_ready` = ~`hold` & (state==IDLE | state is final).
  - Back-to-back instructions therefore incur no IDLE bubble.
- On accept, `instr` is loaded with `instr_in`; otherwise `instr` holds. `instr` is stable for every cycle of an instruction's execution.
- `alu_sub` = `instr[20]` when `instr[22:21]`==01, else 0.
- `done` = (state is final) & ~`hold`.
- `retired` increments when `done` is 1. It wraps from 2^CNT_W−1 to 0 without a flag.
- `hold`=1 freezes `state`, `instr` and `retired`, and forces `done`=0 and `instr_ready`=0. Execution resumes unchanged when `hold` drops.
- Reset values:
  - `state`=00000, `instr`=0, `retired`=0.
  - `done`=0, `illegal`=0, `alu_sub`=0.
  - `instr_ready`=1 when `hold`=0.

## Timing
- All registers update on the rising edge of `clk`. `rst_n`=0 at an edge overrides every other input, including mid-ARITH. The aborted instruction neither retires nor pulses `done`.
- Accept at edge T: `state` shows the first execution code from T for one cycle (LOAD/MOV) or three cycles (ARITH), absent `hold`.
- Latency from accept edge to `done` high: 1 cycle for LOAD/MOV, 3 cycles for ARITH.
- Sustained throughput with `hold`=0: 1 instruction/cycle for LOAD/MOV, 1 per 3 cycles for arithmetic.
- `illegal` is registered: high for the single cycle after the accepting edge.
- `instr_ready` and `done` are combinational from the state register and `hold` only; there is no path from `instr_valid` to `instr_ready`.
- `instr_valid` high with `instr_ready` low: the instruction is not taken and fetch must hold it stable.
- `hold` asserted during ARITH2: the state stays ARITH2 until release, then proceeds to ARITH3.

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - the six state codes;
  - opcode constants;
  - field bit positions (OPC, RX, RY).
- The output-signal decoder must import the same package.
- One natural sub-module, `opcode_classify`: combinational; from the opcode it yields the first state, `is_arith`, `is_sub` and `is_illegal`.
- The sequencer body holds:
  - the state register;
  - the instruction register;
  - the retire counter;
  - the handshake logic.

## Test plan
- Reset, then LOAD `23'h0_3_0000` with valid held 1 cycle → `state`=00001 for 1 cycle, `done`=1, `retired`=1, then IDLE.
- SUB `23'h3_2_1000` → `state` 00011, 00100, 00101 on consecutive cycles; `alu_sub`=1 throughout; `done` only in the 00101 cycle.
- MOV, MOV, ADD offered back-to-back with valid held high → no IDLE between them; `retired`=3 after 5 execution cycles.
- `hold`=1 for 4 cycles during ARITH2 → `state` stays 00100; `instr_ready`=0 and `done`=0 throughout; ARITH3 follows release.
- Opcode 101 accepted → `illegal` pulses 1 cycle, `state` stays 00000, `retired` unchanged.
- `rst_n`=0 during ARITH2 → next cycle all outputs at reset values; preset `retired`=16'hFFFF with one LOAD → wraps to 0.
